// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch stage. Issues sequential word addresses to |
// |               instruction memory, pairs in-order responses with their      |
// |               addresses in a small circular buffer and hands them to       |
// |               Decode. Redirects flush all in-flight work.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-3:0] BOOT_ADDR  = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-3:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_addr,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [ADDR_WIDTH-3:0] insn_addr,
  output logic [31:0]           insn
);

  localparam int                 c_aw      = ADDR_WIDTH - 2;
  localparam int                 c_ptr_w   = $clog2(DEPTH);
  localparam int                 c_cnt_w   = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [c_aw-1:0]             pc_q, pc_d;
  logic [DEPTH-1:0][c_aw-1:0]  addr_q, addr_d;
  logic [DEPTH-1:0][31:0]      data_q, data_d;
  logic [DEPTH-1:0]            filled_q, filled_d;
  logic [c_ptr_w-1:0]          alloc_ptr_q, alloc_ptr_d;
  logic [c_ptr_w-1:0]          fill_ptr_q, fill_ptr_d;
  logic [c_ptr_w-1:0]          head_ptr_q, head_ptr_d;
  logic [c_cnt_w-1:0]          count_q, count_d;
  logic [c_cnt_w-1:0]          drop_cnt_q, drop_cnt_d;

  logic                        w_req_fire;
  logic                        w_insn_fire;
  logic                        w_rsp_fill;
  logic                        w_rsp_drop;
  logic [c_cnt_w-1:0]          w_filled_cnt;
  logic [c_cnt_w-1:0]          w_unanswered;

  // Request channel, head-of-buffer presentation and handshake decode
  always_comb begin
    imem_req_valid = !rst && (count_q < c_depth);
    imem_req_addr  = pc_q;
    insn_valid     = (count_q != '0) && filled_q[head_ptr_q];
    insn_addr      = addr_q[head_ptr_q];
    insn           = data_q[head_ptr_q];
    w_req_fire     = imem_req_valid && imem_req_ready;
    w_insn_fire    = insn_valid && insn_ready;
    w_rsp_drop     = imem_rsp_valid && (drop_cnt_q != '0);
    w_rsp_fill     = imem_rsp_valid && (drop_cnt_q == '0);
  end

  // Allocated-but-unfilled entries are exactly the live outstanding requests
  always_comb begin
    w_filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_filled_cnt = w_filled_cnt + c_cnt_w'(filled_q[i]);
    end
    w_unanswered = count_q - w_filled_cnt;
  end

  // Next-state: allocate on request, fill or drop on response, free on consume, flush on redirect
  always_comb begin
    pc_d        = pc_q;
    addr_d      = addr_q;
    data_d      = data_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    drop_cnt_d  = drop_cnt_q;
    count_d     = count_q + c_cnt_w'(w_req_fire) - c_cnt_w'(w_insn_fire);

    if (w_req_fire) begin
      addr_d[alloc_ptr_q]   = pc_q;
      filled_d[alloc_ptr_q] = 1'b0;
      alloc_ptr_d           = alloc_ptr_q + c_ptr_one;
      pc_d                  = pc_q + 1'b1;
    end

    if (w_rsp_fill) begin
      data_d[fill_ptr_q]   = imem_rsp_data;
      filled_d[fill_ptr_q] = 1'b1;
      fill_ptr_d           = fill_ptr_q + c_ptr_one;
    end

    if (w_rsp_drop) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end

    if (w_insn_fire) begin
      filled_d[head_ptr_q] = 1'b0;
      head_ptr_d           = head_ptr_q + c_ptr_one;
    end

    // Every request still owed a response becomes a drop, including one accepted
    // right now; a response arriving now (kept or dropped) settles one of them.
    if (redirect_valid) begin
      pc_d        = redirect_addr;
      filled_d    = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      drop_cnt_d  = drop_cnt_q + w_unanswered + c_cnt_w'(w_req_fire)
                  - c_cnt_w'(imem_rsp_valid);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= BOOT_ADDR;
      addr_q      <= '0;
      data_q      <= '0;
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
`default_nettype wire
